// File: rtl/ederah_multi_engine_ctrl.sv
// Job controller and stream router for G_NUM_ENGINES ederah engines: NFA broadcast, round-robin query dispatch, in-order result merge.
// Optional job cycle counter enabled by defining EDERAH_JOB_CYCLE_COUNTER_EN.
module ederah_multi_engine_ctrl #(
    parameter int G_DATA_BUS_WIDTH = 512,
    parameter int G_NUM_ENGINES    = 2,
    parameter int G_HASH_WIDTH     = 32,
    parameter int G_PKT_CNT_WIDTH  = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      ap_start_i,
    output logic                                      ap_idle_o,
    output logic                                      ap_done_o,
    output logic                                      ap_ready_o,
    input  logic [G_HASH_WIDTH-1:0]                   nfa_hash_i,
    input  logic                                      force_reload_i,
    input  logic [G_PKT_CNT_WIDTH-1:0]                n_packets_i,
    input  logic [G_DATA_BUS_WIDTH-1:0]               in_data_i,
    input  logic                                      in_valid_i,
    input  logic                                      in_last_i,
    output logic                                      in_ready_o,
    output logic [G_NUM_ENGINES*G_DATA_BUS_WIDTH-1:0] eng_data_o,
    output logic [G_NUM_ENGINES-1:0]                  eng_valid_o,
    output logic [G_NUM_ENGINES-1:0]                  eng_last_o,
    output logic [G_NUM_ENGINES-1:0]                  eng_stype_o,
    input  logic [G_NUM_ENGINES-1:0]                  eng_ready_i,
    input  logic [G_NUM_ENGINES*G_DATA_BUS_WIDTH-1:0] eng_res_data_i,
    input  logic [G_NUM_ENGINES-1:0]                  eng_res_valid_i,
    input  logic [G_NUM_ENGINES-1:0]                  eng_res_last_i,
    output logic [G_NUM_ENGINES-1:0]                  eng_res_ready_o,
    output logic [G_DATA_BUS_WIDTH-1:0]               out_data_o,
    output logic                                      out_valid_o,
    output logic                                      out_last_o,
    output logic [G_DATA_BUS_WIDTH/8-1:0]             out_keep_o,
    input  logic                                      out_ready_i,
    output logic                                      nfa_loaded_o,
    output logic [31:0]                               job_cycles_o
);
    localparam int W     = G_DATA_BUS_WIDTH;
    localparam int N     = G_NUM_ENGINES;
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N - 1);

    // state        | meaning
    // S_IDLE       | waiting for a start edge
    // S_READ_NFA   | broadcasting NFA beats to all engines
    // S_READ_QUERY | dispatching query packets round-robin, merging results
    // S_DRAIN      | all queries sent, merging remaining results
    // S_DONE       | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_READ_NFA, S_READ_QUERY, S_DRAIN, S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic                        ap_start_q;
    logic [G_HASH_WIDTH-1:0]     hash_q, hash_d, pend_hash_q, pend_hash_d;
    logic                        hash_valid_q, hash_valid_d;
    logic [G_PKT_CNT_WIDTH-1:0]  n_pkt_q, n_pkt_d, sent_q, sent_d, recv_q, recv_d;
    logic [SEL_W-1:0]            dsel_q, dsel_d, rsel_q, rsel_d;
    logic [N-1:0]                taken_q, taken_d;
    logic                        start_pulse, reload, in_fire, out_fire;

    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
        return (s == SEL_MAX) ? '0 : s + 1'b1;
    endfunction

    assign start_pulse = ap_start_i & ~ap_start_q;
    assign reload      = force_reload_i | ~hash_valid_q | (nfa_hash_i != hash_q);

    assign eng_data_o   = {N{in_data_i}};
    assign out_data_o   = eng_res_data_i[int'(rsel_q)*W +: W];
    assign out_keep_o   = '1;
    assign ap_idle_o    = (state_q == S_IDLE);
    assign ap_done_o    = (state_q == S_DONE);
    assign ap_ready_o   = ap_done_o;
    assign nfa_loaded_o = hash_valid_q;

    always_comb begin
        state_d         = state_q;
        hash_d          = hash_q;
        pend_hash_d     = pend_hash_q;
        hash_valid_d    = hash_valid_q;
        n_pkt_d         = n_pkt_q;
        sent_d          = sent_q;
        recv_d          = recv_q;
        dsel_d          = dsel_q;
        rsel_d          = rsel_q;
        taken_d         = taken_q;
        in_ready_o      = 1'b0;
        eng_valid_o     = '0;
        eng_last_o      = {N{in_last_i}};
        eng_stype_o     = '0;
        eng_res_ready_o = '0;
        out_valid_o     = 1'b0;
        out_last_o      = 1'b0;
        in_fire         = 1'b0;
        out_fire        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    n_pkt_d     = n_packets_i;
                    pend_hash_d = nfa_hash_i;
                    sent_d      = '0;
                    recv_d      = '0;
                    dsel_d      = '0;
                    rsel_d      = '0;
                    taken_d     = '0;
                    if (reload) begin
                        hash_valid_d = 1'b0;
                        state_d      = S_READ_NFA;
                    end else if (n_packets_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ_QUERY;
                    end
                end
            end
            S_READ_NFA: begin
                // Host beat completes only once every engine has taken it
                eng_valid_o = {N{in_valid_i}} & ~taken_q;
                in_ready_o  = &(eng_ready_i | taken_q);
                in_fire     = in_valid_i & in_ready_o;
                if (in_fire) begin
                    taken_d = '0;
                    if (in_last_i) begin
                        hash_d       = pend_hash_q;
                        hash_valid_d = 1'b1;
                        state_d      = (n_pkt_q == '0) ? S_DONE : S_READ_QUERY;
                    end
                end else begin
                    taken_d = taken_q | (eng_valid_o & eng_ready_i);
                end
            end
            S_READ_QUERY: begin
                eng_stype_o         = '1;
                eng_valid_o[dsel_q] = in_valid_i;
                in_ready_o          = eng_ready_i[dsel_q];
                in_fire             = in_valid_i & in_ready_o;
                if (in_fire && in_last_i) begin
                    sent_d = sent_q + 1'b1;
                    dsel_d = sel_next(dsel_q);
                    if (sent_q + 1'b1 == n_pkt_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: ;
            S_DONE: begin
                sent_d  = '0;
                recv_d  = '0;
                dsel_d  = '0;
                rsel_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_READ_QUERY || state_q == S_DRAIN) begin
            out_valid_o             = eng_res_valid_i[rsel_q];
            eng_res_ready_o[rsel_q] = out_ready_i;
            out_last_o              = eng_res_last_i[rsel_q] & (recv_q == n_pkt_q - 1'b1);
            out_fire                = out_valid_o & out_ready_i;
            if (out_fire && eng_res_last_i[rsel_q]) begin
                recv_d = recv_q + 1'b1;
                rsel_d = sel_next(rsel_q);
            end
            if (out_fire && out_last_o) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ap_start_q   <= 1'b0;
            hash_q       <= '0;
            pend_hash_q  <= '0;
            hash_valid_q <= 1'b0;
            n_pkt_q      <= '0;
            sent_q       <= '0;
            recv_q       <= '0;
            dsel_q       <= '0;
            rsel_q       <= '0;
            taken_q      <= '0;
        end else begin
            state_q      <= state_d;
            ap_start_q   <= ap_start_i;
            hash_q       <= hash_d;
            pend_hash_q  <= pend_hash_d;
            hash_valid_q <= hash_valid_d;
            n_pkt_q      <= n_pkt_d;
            sent_q       <= sent_d;
            recv_q       <= recv_d;
            dsel_q       <= dsel_d;
            rsel_q       <= rsel_d;
            taken_q      <= taken_d;
        end
    end

`ifdef EDERAH_JOB_CYCLE_COUNTER_EN
    logic [31:0] job_cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            job_cycles_q <= '0;
        end else if (state_q == S_IDLE && start_pulse) begin
            job_cycles_q <= '0;
        end else if (state_q != S_IDLE && job_cycles_q != 32'hFFFF_FFFF) begin
            job_cycles_q <= job_cycles_q + 32'd1;
        end
    end

    assign job_cycles_o = job_cycles_q;
`else
    assign job_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ederah_multi_engine_ctrl.sv
// Randomized bench for ederah_multi_engine_ctrl: behavioural engine/host models, expected routing and merge order from job rules.
module tb_ederah_multi_engine_ctrl;
    localparam int W  = 32;
    localparam int N  = 2;
    localparam int HW = 32;
    localparam int PW = 16;
    localparam logic [W-1:0] RES_X = 32'h5A5A_5A5A;

    typedef logic [W+1:0] beat_t;  // {stype, last, data}

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            ap_start_i, ap_idle_o, ap_done_o, ap_ready_o;
    logic [HW-1:0]   nfa_hash_i;
    logic            force_reload_i;
    logic [PW-1:0]   n_packets_i;
    logic [W-1:0]    in_data_i;
    logic            in_valid_i, in_last_i, in_ready_o;
    logic [N*W-1:0]  eng_data_o;
    logic [N-1:0]    eng_valid_o, eng_last_o, eng_stype_o, eng_ready_i;
    logic [N*W-1:0]  eng_res_data_i;
    logic [N-1:0]    eng_res_valid_i, eng_res_last_i, eng_res_ready_o;
    logic [W-1:0]    out_data_o;
    logic            out_valid_o, out_last_o, out_ready_i;
    logic [W/8-1:0]  out_keep_o;
    logic            nfa_loaded_o;
    logic [31:0]     job_cycles_o;

    ederah_multi_engine_ctrl #(
        .G_DATA_BUS_WIDTH(W), .G_NUM_ENGINES(N), .G_HASH_WIDTH(HW), .G_PKT_CNT_WIDTH(PW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ap_start_i(ap_start_i), .ap_idle_o(ap_idle_o),
        .ap_done_o(ap_done_o), .ap_ready_o(ap_ready_o), .nfa_hash_i(nfa_hash_i),
        .force_reload_i(force_reload_i), .n_packets_i(n_packets_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
        .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o), .eng_last_o(eng_last_o),
        .eng_stype_o(eng_stype_o), .eng_ready_i(eng_ready_i),
        .eng_res_data_i(eng_res_data_i), .eng_res_valid_i(eng_res_valid_i),
        .eng_res_last_i(eng_res_last_i), .eng_res_ready_o(eng_res_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
        .out_keep_o(out_keep_o), .out_ready_i(out_ready_i),
        .nfa_loaded_o(nfa_loaded_o), .job_cycles_o(job_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    beat_t        host_q[$];
    beat_t        eng_log[N][$];
    beat_t        exp_log[N][$];
    logic [W:0]   res_q[N][$];
    logic [W:0]   out_log[$];
    logic [W:0]   exp_out[$];
    int           done_cnt, done_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        ap_start_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
        eng_ready_i = '0; eng_res_valid_i = '0; eng_res_last_i = '0; eng_res_data_i = '0;
        out_ready_i = 1'b0;
    endtask

    task automatic clear_models();
        host_q.delete(); out_log.delete(); exp_out.delete();
        for (int k = 0; k < N; k++) begin
            eng_log[k].delete(); exp_log[k].delete(); res_q[k].delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_idle"}, ap_idle_o, 1);
        check({tag, "_done"}, ap_done_o, 0);
        check({tag, "_eng_valid"}, eng_valid_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_in_ready"}, in_ready_o, 0);
        check({tag, "_nfa_loaded"}, nfa_loaded_o, 0);
    endtask

    // Runs one job; caller is positioned 1 time unit after a rising edge.
    task automatic run_job(input string tag, input logic [HW-1:0] hash, input logic frc, input int npk,
                           input logic exp_reload, input int bp, input int hold0, input int abort_at,
                           input int exp_done_cyc);
        int cyc, out_pkt, nfa_left, rs, timed_out;
        int viol_rr, viol_ov, viol_bp, viol_nl;
        logic held;
        logic [W-1:0] d;
        clear_models();
        nfa_left = 0;
        if (exp_reload) begin
            nfa_left = $urandom_range(4, 2);
            for (int i = 0; i < nfa_left; i++) begin
                d = $urandom;
                host_q.push_back({1'b0, (i == nfa_left - 1), d});
                for (int k = 0; k < N; k++) exp_log[k].push_back({1'b0, (i == nfa_left - 1), d});
            end
        end
        for (int p = 0; p < npk; p++) begin
            int len = $urandom_range(3, 1);
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                host_q.push_back({1'b1, (b == len - 1), d});
                exp_log[p % N].push_back({1'b1, (b == len - 1), d});
                exp_out.push_back({(p == npk - 1) && (b == len - 1), d ^ RES_X});
            end
        end
        cyc = 0; out_pkt = 0; held = 0; timed_out = 0;
        viol_rr = 0; viol_ov = 0; viol_bp = 0; viol_nl = 0;
        done_cnt = 0; done_cyc = -1;
        nfa_hash_i = hash; force_reload_i = frc; n_packets_i = PW'(npk);
        while (1) begin
            ap_start_i = 1'b1;
            in_valid_i = (host_q.size() > 0) && (held || (cyc <= bp) || $urandom_range(3) != 0);
            if (host_q.size() > 0) {in_last_i, in_data_i} = host_q[0][W:0];
            for (int k = 0; k < N; k++) eng_ready_i[k] = ($urandom_range(3) != 0);
            if (cyc >= 1 && cyc <= bp) eng_ready_i = 2'b01;
            for (int k = 0; k < N; k++) begin
                eng_res_valid_i[k] = (res_q[k].size() > 0) && ($urandom_range(3) != 0);
                if (k == 0 && cyc < hold0) eng_res_valid_i[k] = 1'b0;
                if (res_q[k].size() > 0) {eng_res_last_i[k], eng_res_data_i[k*W +: W]} = res_q[k][0];
            end
            out_ready_i = ($urandom_range(3) != 0);
            #1;
            rs = out_pkt % N;
            for (int k = 0; k < N; k++) if (k != rs && eng_res_ready_o[k]) viol_rr++;
            if (out_valid_o !== eng_res_valid_i[rs]) viol_ov++;
            if (cyc >= 1 && cyc <= bp && in_ready_o !== 1'b0) viol_bp++;
            if (exp_reload && cyc >= 1 && nfa_left > 0 && nfa_loaded_o !== 1'b0) viol_nl++;
            if (out_valid_o && out_ready_i) begin
                out_log.push_back({out_last_o, out_data_o});
                if (res_q[rs].size() > 0) begin
                    if (res_q[rs][0][W]) out_pkt++;
                    void'(res_q[rs].pop_front());
                end
            end
            for (int k = 0; k < N; k++) begin
                if (eng_valid_o[k] && eng_ready_i[k]) begin
                    eng_log[k].push_back({eng_stype_o[k], eng_last_o[k], eng_data_o[k*W +: W]});
                    if (eng_stype_o[k]) res_q[k].push_back({eng_last_o[k], eng_data_o[k*W +: W] ^ RES_X});
                end
            end
            if (in_valid_i && in_ready_o) begin
                if (!host_q[0][W+1]) nfa_left--;
                void'(host_q.pop_front());
                held = 1'b0;
            end else begin
                held = in_valid_i;
            end
            if (ap_done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == abort_at) break;
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            if (cyc > 1500) begin timed_out = 1; break; end
            @(posedge clk_i); #1;
            cyc++;
        end
        if (abort_at >= 0) begin
            check({tag, "_no_done_before_abort"}, done_cnt, 0);
            return;
        end
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_idle_after"}, ap_idle_o, 1);
        check({tag, "_nfa_loaded_after"}, nfa_loaded_o, 1);
        check({tag, "_keep"}, out_keep_o, 4'hF);
        check({tag, "_res_ready_other"}, viol_rr, 0);
        check({tag, "_out_valid_follow"}, viol_ov, 0);
        if (bp > 0) check({tag, "_bp_in_ready_low"}, viol_bp, 0);
        if (exp_reload) check({tag, "_nfa_loaded_low"}, viol_nl, 0);
        if (exp_done_cyc >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_eng%0d_count", tag, k), eng_log[k].size(), exp_log[k].size());
            for (int i = 0; i < exp_log[k].size() && i < eng_log[k].size(); i++)
                check($sformatf("%s_eng%0d_beat%0d", tag, k, i), eng_log[k][i], exp_log[k][i]);
        end
        check({tag, "_out_count"}, out_log.size(), exp_out.size());
        for (int i = 0; i < exp_out.size() && i < out_log.size(); i++)
            check($sformatf("%s_out%0d", tag, i), out_log[i], exp_out[i]);
`ifdef EDERAH_JOB_CYCLE_COUNTER_EN
        check({tag, "_job_cycles"}, job_cycles_o, done_cyc);
`else
        check({tag, "_job_cycles"}, job_cycles_o, 0);
`endif
        quiet();
        @(posedge clk_i); #1;
    endtask

    initial begin
        quiet();
        nfa_hash_i = '0; force_reload_i = 1'b0; n_packets_i = '0;
        rst_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i); #1;
        check_idle_outputs("reset");
        check("reset_job_cycles", job_cycles_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // first job always reloads; engine 1 back-pressures the broadcast
        run_job("job_first", 32'h1234, 1'b0, 4, 1'b1, 3, 0, -1, -1);
        // same hash: queries straight away; engine 0 results held back
        run_job("job_same_hash", 32'h1234, 1'b0, 4, 1'b0, 0, 14, -1, -1);
        run_job("job_force", 32'h1234, 1'b1, 3, 1'b1, 0, 0, -1, -1);
        run_job("job_zero_pkts", 32'h1234, 1'b0, 0, 1'b0, 0, 0, -1, 1);
        run_job("job_new_hash", 32'hBEEF, 1'b0, 5, 1'b1, 0, 0, -1, -1);
        run_job("job_reload_zero", 32'hCAFE, 1'b0, 0, 1'b1, 0, 0, -1, -1);

        run_job("job_abort", 32'hCAFE, 1'b0, 4, 1'b0, 0, 0, 6, -1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_idle_outputs("mid_reset");
        rst_i = 1'b0;
        quiet();
        clear_models();
        @(posedge clk_i); #1;
        run_job("job_after_reset", 32'hCAFE, 1'b0, 3, 1'b1, 0, 0, -1, -1);

        for (int j = 0; j < 4; j++) begin
            logic f;
            f = 1'($urandom_range(1));
            run_job($sformatf("job_rand%0d", j), 32'hCAFE, f, $urandom_range(6, 1), f, 0, 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
